// File: rtl/vertex_streamer.sv
// vertex_streamer: walks one object's vertex list in a synchronous-read
// vertex memory and presents each vertex as four float32 words to the
// transformation stage over a valid/ready handshake.
//
// Build option: define LOOP_EN to make the block restart from the latched
// base/count after every pass, so it streams continuously until reset.
// Without LOOP_EN, each accepted start_in produces a single pass.

module vertex_streamer #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W:0]   vert_count_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [127:0]      data_in,
  output logic [31:0]       pos_out [3:0],
  output logic              valid_out,
  input  logic              ready_in,
  output logic              obj_done_out,
  output logic              busy_out,
  output logic              frame_done_out
);

  // Latency counter counts 0..READ_LAT while a read is in flight.
  localparam int LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   idx_r;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic              last_s;

  // The vertex currently being fetched/presented is the object's final one.
  assign last_s = (idx_r == (count_r - IDX_ONE));

  // Streaming state machine; every output is a register updated here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r        <= ST_IDLE;
      base_r         <= '0;
      count_r        <= '0;
      idx_r          <= '0;
      lat_cnt_r      <= '0;
      rd_en_out      <= 1'b0;
      addr_out       <= '0;
      valid_out      <= 1'b0;
      obj_done_out   <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos_out[i] <= 32'h0000_0000;
      end
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rd_en_out      <= 1'b0;
      frame_done_out <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            base_r  <= base_addr_in;
            count_r <= vert_count_in;
            if (vert_count_in == '0) begin
              // Empty object: report completion without touching memory.
              frame_done_out <= 1'b1;
            end else begin
              busy_out  <= 1'b1;
              rd_en_out <= 1'b1;
              addr_out  <= base_addr_in;
              idx_r     <= '0;
              lat_cnt_r <= '0;
              state_r   <= ST_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            pos_out[0]   <= data_in[31:0];
            pos_out[1]   <= data_in[63:32];
            pos_out[2]   <= data_in[95:64];
            pos_out[3]   <= data_in[127:96];
            valid_out    <= 1'b1;
            obj_done_out <= last_s;
            state_r      <= ST_PRESENT;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_ONE;
          end
        end
        ST_PRESENT: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            lat_cnt_r <= '0;
            if (!last_s) begin
              // Next vertex; address wraps silently at 2**ADDR_W.
              idx_r     <= idx_r + IDX_ONE;
              addr_out  <= addr_out + ADDR_ONE;
              rd_en_out <= 1'b1;
              state_r   <= ST_WAIT;
            end else begin
              frame_done_out <= 1'b1;
              obj_done_out   <= 1'b0;
`ifdef LOOP_EN
              idx_r     <= '0;
              addr_out  <= base_r;
              rd_en_out <= 1'b1;
              state_r   <= ST_WAIT;
`else
              busy_out <= 1'b0;
              state_r  <= ST_IDLE;
`endif
            end
          end else begin
            // Stall: hold pos/obj_done/valid until the transfer happens.
            state_r <= ST_PRESENT;
          end
        end
        default: begin
          valid_out    <= 1'b0;
          obj_done_out <= 1'b0;
          busy_out     <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_streamer.sv
// Directed testbench for vertex_streamer (ADDR_W=4, READ_LAT=2) with a
// behavioural synchronous-read vertex memory.
module tb_vertex_streamer;

  localparam int AW = 4;
  localparam int RL = 2;
  localparam int P  = RL + 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   vert_count_in;
  logic          rd_en_out;
  logic [AW-1:0] addr_out;
  logic [127:0]  data_in;
  logic [31:0]   pos_out [3:0];
  logic          valid_out;
  logic          ready_in;
  logic          obj_done_out;
  logic          busy_out;
  logic          frame_done_out;

  int n_cmp = 0;
  int n_bad = 0;

  vertex_streamer #(.ADDR_W(AW), .READ_LAT(RL)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .vert_count_in(vert_count_in),
    .rd_en_out(rd_en_out), .addr_out(addr_out), .data_in(data_in),
    .pos_out(pos_out), .valid_out(valid_out), .ready_in(ready_in),
    .obj_done_out(obj_done_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [127:0] vdata(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {{(32-AW){1'b0}}, a};
    return {32'h3000_0000 | x, 32'h2000_0000 | x, 32'h1000_0000 | x, 32'h0A00_0000 | x};
  endfunction

  // Memory model: samples the strobe, data appears RL edges later; junk otherwise.
  logic [127:0] pipe [RL];
  always @(posedge clk_in) begin
    pipe[0] <= rd_en_out ? vdata(addr_out) : {4{32'hDEAD_BEEF}};
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign data_in = pipe[RL-1];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n_in = 1'b0; start_in = 1'b0; ready_in = 1'b0;
    base_addr_in = '0; vert_count_in = '0;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if ({rd_en_out, valid_out, obj_done_out, busy_out, frame_done_out, addr_out} !== '0 ||
        pos_out[0] !== 32'h0 || pos_out[3] !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: got ctl=%b addr=%0d pos0=%h want all zero",
               {rd_en_out, valid_out, obj_done_out, busy_out, frame_done_out}, addr_out, pos_out[0]);
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  // Start one object with ready tied high and check every cycle.
  task automatic run_stream(input logic [AW-1:0] base, input logic [AW:0] cnt,
                            input int ncyc, input bit poke, input string nm);
    int cn, k, ph, kk;
    bit act, rd_e, val_e, fr_e, busy_e, od_e;
    logic [AW-1:0] ea;
    logic [4:0] got, exp;
    cn = int'(cnt);
    @(negedge clk_in);
    start_in = 1'b1; base_addr_in = base; vert_count_in = cnt; ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk_in);
      k = c / P; ph = c % P;
`ifdef LOOP_EN
      act = (cn != 0); kk = (cn != 0) ? (k % cn) : 0;
      fr_e = (cn == 0) ? (c == 0) : (c > 0 && (c % (cn * P)) == 0);
      busy_e = (cn != 0);
`else
      act = (k < cn); kk = k;
      fr_e = (c == cn * P);
      busy_e = (c < cn * P);
`endif
      rd_e  = act && (ph == 0);
      val_e = act && (ph == RL + 1);
      od_e  = val_e && (kk == cn - 1);
      ea    = base + AW'(kk);
      got = {rd_en_out, valid_out, frame_done_out, busy_out, obj_done_out};
      exp = {rd_e, val_e, fr_e, busy_e, od_e};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s_ctl c=%0d: got rd/val/fr/busy/od=%b want %b", nm, c, got, exp);
      end
      if (rd_e) begin
        n_cmp++;
        if (addr_out !== ea) begin
          n_bad++;
          $display("FAIL %s_addr c=%0d: got %0d want %0d", nm, c, addr_out, ea);
        end
      end
      if (val_e) begin
        n_cmp++;
        if (pos_out[0] !== (32'h0A00_0000 | 32'(ea)) || pos_out[3] !== (32'h3000_0000 | 32'(ea))) begin
          n_bad++;
          $display("FAIL %s_pos c=%0d: got %h/%h want vertex %0d", nm, c, pos_out[3], pos_out[0], ea);
        end
      end
      if (poke && c == 1) begin
        start_in = 1'b1; base_addr_in = 4'd8; vert_count_in = 5'd5;
      end else begin
        start_in = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (valid_out !== 1'b1 && n < 12) begin
      @(negedge clk_in); n++;
    end
    if (valid_out !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_wait: got valid=%b want 1 within 12 cycles", nm, valid_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    run_stream(4'd5, 5'd3, 16, 1'b1, "basic");
  endtask

  task automatic test_empty();
    do_reset();
    run_stream(4'd4, 5'd0, 8, 1'b0, "empty");
  endtask

  task automatic test_wrap();
    do_reset();
    run_stream(4'd14, 5'd4, 20, 1'b0, "wrap");
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk_in);
    start_in = 1'b1; base_addr_in = 4'd2; vert_count_in = 5'd2; ready_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_valid("stall1");
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (valid_out !== 1'b1 || rd_en_out !== 1'b0 || obj_done_out !== 1'b0 ||
          pos_out[0] !== 32'h0A00_0002 || pos_out[2] !== 32'h2000_0002) begin
        n_bad++;
        $display("FAIL stall_hold i=%0d: got val=%b rd=%b od=%b pos0=%h want 1 0 0 0a000002",
                 i, valid_out, rd_en_out, obj_done_out, pos_out[0]);
      end
      @(negedge clk_in);
    end
    ready_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (valid_out !== 1'b0 || rd_en_out !== 1'b1 || addr_out !== 4'd3) begin
      n_bad++;
      $display("FAIL stall_release: got val=%b rd=%b addr=%0d want 0 1 3", valid_out, rd_en_out, addr_out);
    end
    wait_valid("stall2");
    n_cmp++;
    if (pos_out[0] !== 32'h0A00_0003 || obj_done_out !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_last: got pos0=%h od=%b want 0a000003 1", pos_out[0], obj_done_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (frame_done_out !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_frame: got fr=%b val=%b want 1 0", frame_done_out, valid_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_in);
    start_in = 1'b1; base_addr_in = 4'd9; vert_count_in = 5'd2; ready_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_valid("rstmid");
    #2 rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({rd_en_out, valid_out, obj_done_out, busy_out, frame_done_out} !== 5'b0 ||
        addr_out !== 4'd0 || pos_out[0] !== 32'h0 || pos_out[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_async: got ctl=%b addr=%0d pos0=%h want zero",
               {rd_en_out, valid_out, obj_done_out, busy_out, frame_done_out}, addr_out, pos_out[0]);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    run_stream(4'd3, 5'd2, 12, 1'b0, "after_rst");
  endtask

`ifdef LOOP_EN
  task automatic test_loop();
    do_reset();
    run_stream(4'd0, 5'd2, 26, 1'b1, "loop");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_wrap();
    test_stall();
    test_reset_mid();
`ifdef LOOP_EN
    test_loop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
